// File: rtl/mult_iter.sv
// Iterative digit-serial multiplier: consumes DIGIT multiplier bits per cycle,
// stopping early once the remaining multiplier bits are all zero.
module mult_iter #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic             sign,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  localparam int PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [PW-1:0]    ONE_P = PW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mp_q, mp_d;
  logic [PW-1:0]     mc_q, mc_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     count_q, count_d;
  logic              neg_q, neg_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  logic [PW-1:0]     dig_ext;
  logic [PW-1:0]     prod;
  logic [PW-1:0]     acc_nx;
  logic [PW-1:0]     res;
  logic [WIDTH-1:0]  mp_sh;
  logic [CW-1:0]     cnt_nx;

  // Magnitude as an unsigned quantity; the most-negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? (~x + ONE_W) : x;
  endfunction

  assign dig_ext = PW'(mp_q[DIGIT-1:0]);
  assign prod    = dig_ext * mc_q;
  assign acc_nx  = acc_q + prod;
  assign res     = neg_q ? (~acc_nx + ONE_P) : acc_nx;
  assign mp_sh   = mp_q >> DIGIT;
  assign cnt_nx  = count_q + CW'(1);

  always_comb begin
    state_d = state_q;
    mp_d    = mp_q;
    mc_d    = mc_q;
    acc_d   = acc_q;
    count_d = count_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            state_d = RUN;
            mp_d    = mag(src_a, sign);
            mc_d    = PW'(mag(src_b, sign));
            acc_d   = '0;
            count_d = '0;
            neg_d   = sign & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          end
        end
        RUN: begin
          acc_d   = acc_nx;
          mp_d    = mp_sh;
          mc_d    = mc_q << DIGIT;
          count_d = cnt_nx;
          // Nothing left to add once the remaining multiplier bits are zero.
          if (mp_sh == '0 || cnt_nx == CW'(N)) begin
            state_d = DONE;
            hi_d    = res[PW-1:WIDTH];
            lo_d    = res[WIDTH-1:0];
          end
        end
        DONE: begin
          if (ready_in) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mp_q    <= '0;
      mc_q    <= '0;
      acc_q   <= '0;
      count_q <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      mp_q    <= mp_d;
      mc_q    <= mc_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign ready_out = (state_q == IDLE);
  assign valid_out = (state_q == DONE);
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_mult_iter.sv
// Scoreboard bench for mult_iter (WIDTH=32, DIGIT=8): directed operand vectors,
// result and latency checked by an independent monitor process.
module tb_mult_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic        sign = 1'b0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        valid_out;
  logic        ready_in = 1'b1;
  logic [31:0] hi;
  logic [31:0] lo;

  mult_iter #(.WIDTH(32), .DIGIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
    .sign(sign), .src_a(src_a), .src_b(src_b), .flush(flush),
    .valid_out(valid_out), .ready_in(ready_in), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] h;
    logic [31:0] l;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc = 0;
  int   nchk = 0;
  int   nfail = 0;
  bit   vprev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one comparison set per new result presented on valid_out.
  always @(negedge clk) begin
    if (!rst_n) begin
      vprev = 1'b0;
    end else begin
      if (valid_out && !vprev) begin
        if (sbq.size() == 0) begin
          nchk++;
          nfail++;
          $display("FAIL unexpected_valid: got hi=%h lo=%h expected no result", hi, lo);
        end else begin
          mon_e = sbq.pop_front();
          check("hi", 64'(hi), 64'(mon_e.h));
          check("lo", 64'(lo), 64'(mon_e.l));
          check("latency", 64'(cyc - mon_e.acc_cyc), 64'(mon_e.lat));
        end
      end
      vprev = valid_out;
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready_out) return;
    end
    nchk++;
    nfail++;
    $display("FAIL ready_timeout: got ready_out=0 expected 1");
  endtask

  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int lat,
                       input bit expect_res);
    wait_ready();
    valid_in = 1'b1;
    sign     = s;
    src_a    = a;
    src_b    = b;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    src_a    = $urandom;
    src_b    = $urandom;
    sign     = 1'($urandom);
    if (expect_res) sbq.push_back('{eh, el, lat, cyc});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    #1;
    check("rst_ready", 64'(ready_out), 64'd1);
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed products
    do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 4, 1'b1);
    do_op(1'b1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1, 1'b1);
    do_op(1'b0, 32'hFFFFFFFD, 32'h00000005, 32'h00000004, 32'hFFFFFFF1, 4, 1'b1);
    do_op(1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 4, 1'b1);
    do_op(1'b0, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 1, 1'b1);
    do_op(1'b0, 32'h00000100, 32'h12345678, 32'h00000012, 32'h34567800, 2, 1'b1);
    do_op(1'b1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 1, 1'b1);
    do_op(1'b0, 32'h00000003, 32'h00000007, 32'h00000000, 32'h00000015, 1, 1'b1);
    do_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1, 1'b1);
    do_op(1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 3, 1'b1);

    // flush beats acceptance on the same edge
    wait_ready();
    valid_in = 1'b1;
    flush    = 1'b1;
    src_a    = 32'h5;
    src_b    = 32'h5;
    @(posedge clk);
    #1;
    check("flush_accept_ready", 64'(ready_out), 64'd1);
    valid_in = 1'b0;
    flush    = 1'b0;

    // Result held while consumer stalls; DONE with valid_in must not accept
    ready_in = 1'b0;
    do_op(1'b0, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1, 1'b1);
    for (int i = 0; i < 50 && !valid_out; i++) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(valid_out), 64'd1);
      check("hold_lo", 64'(lo), 64'd6);
      check("hold_hi", 64'(hi), 64'd0);
    end
    valid_in = 1'b1;
    sign     = 1'b0;
    src_a    = 32'h5;
    src_b    = 32'h5;
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    check("done_no_accept_ready", 64'(ready_out), 64'd1);
    check("done_no_accept_valid", 64'(valid_out), 64'd0);
    valid_in = 1'b0;
    @(negedge clk);
    check("idle_keeps_lo", 64'(lo), 64'd6);

    // flush during the second RUN cycle
    do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_run_ready", 64'(ready_out), 64'd1);
    check("flush_run_valid", 64'(valid_out), 64'd0);
    check("flush_keeps_lo", 64'(lo), 64'd6);
    repeat (8) @(negedge clk);
    do_op(1'b1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1, 1'b1);

    // asynchronous reset during RUN
    do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_run_ready", 64'(ready_out), 64'd1);
    check("rst_run_valid", 64'(valid_out), 64'd0);
    check("rst_run_hi", 64'(hi), 64'd0);
    check("rst_run_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 4, 1'b1);

    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      nchk++;
      nfail++;
      $display("FAIL drain: got %0d pending results expected 0", sbq.size());
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/mult_iter.md
MULT_ITER -- requirements
Module: mult_iter

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; SHALL be a multiple of DIGIT.
REQ-002 Parameter DIGIT, default 8, multiplier bits consumed per RUN cycle; N = WIDTH/DIGIT.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 valid_in  in  1  operand request.
REQ-006 ready_out  out  1  block can accept operands.
REQ-007 sign  in  1  1 = signed two's-complement multiply, 0 = unsigned; sampled at acceptance.
REQ-008 src_a  in  WIDTH  multiplier operand.
REQ-009 src_b  in  WIDTH  multiplicand operand.
REQ-010 flush  in  1  synchronous abort.
REQ-011 valid_out  out  1  result available.
REQ-012 ready_in  in  1  consumer accepts result.
REQ-013 hi  out  WIDTH  upper half of 2*WIDTH-bit product.
REQ-014 lo  out  WIDTH  lower half of product.

Function
REQ-015 The block SHALL implement states IDLE, RUN and DONE.
REQ-016 ready_out SHALL be 1 exactly in IDLE; valid_out SHALL be 1 exactly in DONE.
REQ-017 Acceptance SHALL occur on an edge with IDLE, valid_in=1, flush=0, and SHALL then enter RUN.
REQ-018 At acceptance: mp = |src_a|, mc = |src_b| zero-extended to 2*WIDTH, when sign=1; raw values when sign=0.
REQ-019 |x| of the most-negative value SHALL be 2^(WIDTH-1) as an unsigned WIDTH-bit quantity.
REQ-020 At acceptance: neg = sign & (src_a[WIDTH-1] ^ src_b[WIDTH-1]); acc = 0; count = 0.
REQ-021 Each RUN edge: acc += mp[DIGIT-1:0]*mc (2*WIDTH-bit, modulo 2^(2*WIDTH)); mp >>= DIGIT; mc <<= DIGIT; count += 1.
REQ-022 RUN SHALL go to DONE on the edge where the shifted mp is zero or count reaches N (early termination).
REQ-023 On the RUN->DONE edge {hi,lo} SHALL load neg ? -acc_next : acc_next (two's complement, 2*WIDTH bits).
REQ-024 Latency acceptance edge -> valid_out high = max(1, ceil(bitlen(mp)/DIGIT)) cycles; N cycles worst case.
REQ-025 hi, lo and valid_out SHALL stay stable in DONE until an edge with ready_in=1, which returns to IDLE.
REQ-026 valid_in SHALL be ignored outside IDLE; operands may change freely after acceptance.
REQ-027 flush=1 on any edge SHALL force IDLE, discard the operation and drop valid_out next cycle.
REQ-028 flush SHALL override acceptance and result handshake on the same edge.
REQ-029 hi/lo SHALL keep their last loaded value outside DONE.
REQ-030 DONE with ready_in=1 and valid_in=1 on the same edge SHALL NOT accept; acceptance needs IDLE.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, ready_out=1, valid_out=0, hi=0, lo=0, acc=0, count=0, neg=0.
REQ-032 Reset during RUN or DONE SHALL discard the operation; no valid_out SHALL follow.
REQ-033 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification (WIDTH=32, DIGIT=8)
REQ-034 Unsigned 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, valid_out 4 cycles after acceptance.
REQ-035 Signed 0xFFFFFFFD*0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1, latency 1; same operands unsigned -> hi=0x00000004, lo=0xFFFFFFF1, latency 4.
REQ-036 Signed 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000, latency 4.
REQ-037 src_a=0, src_b=0x12345678 -> hi=lo=0, latency 1; src_a=0x00000100 -> latency 2.
REQ-038 Hold ready_in=0 for 3 cycles in DONE -> hi/lo/valid_out unchanged; ready_in=1 -> IDLE, ready_out=1 next cycle.
REQ-039 flush in RUN cycle 2, or rst_n low in RUN -> IDLE, no valid_out; next operation result correct.
